lfsr6_checker: RTL and testbench
================================

# lfsr6_checker

Receive-side checker for the 6-bit maximal-length LFSR stream produced by the team's generator (`next(q) = {q[4:0], q[5]^q[4]}`, period 63, all-zero illegal). It samples the generator's parallel output, self-synchronises to it, flywheels through corrupted words, and reports lock status, a per-word error pulse, and a saturating error count. It sits downstream of the generator on link and self-test paths and replaces software-side sequence decoding.

## Interface
- `LOCK_CNT`, 4: consecutive matching words after the seed needed to declare lock (1..15).
- `UNLOCK_CNT`, 3: consecutive mismatches in LOCKED that drop lock (1..15).
- `ERR_W`, 16: width of `err_count`.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: `in_data` is valid this cycle (generator `enable`).
- `in_data` input 6: generator output word.
- `err_clr` input 1: synchronous clear of `err_count`.
- `locked` output 1: checker is in LOCKED.
- `err` output 1: one-cycle pulse per mismatched word while LOCKED.
- `err_count` output ERR_W: saturating count of `err` pulses.
- `index` output 6: sequence position of the current word, 1..63; 0 when not locked (see Configuration).

## Operation
- Internal state: `st` ∈ {HUNT, VERIFY, LOCKED}, `pred[5:0]` (expected next word), `match_cnt`, `miss_cnt`.
- Words are processed only when `in_valid`=1. When `in_valid`=0, all state and outputs hold, except that `err` returns to 0.
- Sequence position: 000001 is position 1, and each `next()` step adds 1. For example, 010000 is 5, 100001 is 6, and 100000 is 63. Position 63 wraps to 1.
- **HUNT:**
  - `in_data`=0: ignored.
  - Otherwise: `pred`←next(`in_data`), `match_cnt`←0, go to VERIFY.
- **VERIFY:**
  - `in_data`==`pred`: `match_cnt`++ and `pred`←next(`in_data`). When `match_cnt` reaches `LOCK_CNT`, go to LOCKED with `miss_cnt`←0.
  - Mismatch with nonzero `in_data`: reseed (`pred`←next(`in_data`), `match_cnt`←0) and stay in VERIFY.
  - Mismatch with `in_data`=0: go to HUNT.
  - No errors are counted in VERIFY.
- **LOCKED:**
  - Match: `pred`←next(`in_data`), `miss_cnt`←0.
  - Mismatch, including 0: `err` pulses and `err_count`++ (saturates at all-ones). The checker flywheels with `pred`←next(`pred`), never reseeding from bad data, and `miss_cnt`++.
  - When `miss_cnt` reaches `UNLOCK_CNT`, go to HUNT. The word that causes unlock is still counted as an error.
- `err_clr`=1 forces `err_count` to 0 on the next edge. If an error occurs in the same cycle, clear wins and the result is 0.

## Timing
- All outputs are registered. A word accepted at edge n affects `locked`, `err`, `err_count` and `index` after edge n.
- Lock latency:
  - 1 seed word plus `LOCK_CNT` matching words.
  - `locked` rises after the edge that samples the `LOCK_CNT`-th match.
  - With defaults, the 5th valid word produces the rise.
- Unlock latency: `locked` falls after the edge that samples the `UNLOCK_CNT`-th consecutive mismatch.
- `err` is high for exactly one cycle per mismatched word. Back-to-back mismatches produce consecutive high cycles.
- Reset values (asynchronous assertion clears immediately, including mid-lock):
  - `locked`=0, `err`=0, `err_count`=0, `index`=0.
  - `st`=HUNT, `pred`=0, both counters=0.
- No combinational path from inputs to outputs.

## Configuration
- `LFSR6_CHK_INDEX_EN` defined:
  - Compiles in a 63-entry state→position lookup and a position register.
  - In LOCKED, `index` is the position of the accepted word, or of `pred` when flywheeling on a mismatch. It increments by 1 per valid word and wraps 63→1.
  - `index` reads 0 in HUNT and VERIFY.
- Undefined: no lookup logic is built and `index` is tied to 0. All other behaviour is identical.

## Test plan
- **Lock from reset** (defaults, index enabled). After reset, drive 000001, 000010, 000100, 001000, 010000 with `in_valid`=1 every cycle → `locked`=1 after the 5th edge, `index`=5, `err`=0 throughout.
- **Single corrupt word.** While locked, replace expected 000011 (position 7) with 111111 → `err` high 1 cycle, `err_count`=1, `locked` stays 1, `index`=7. The following 000110 matches, `index`=8, no error.
- **Loss of lock.** While locked, send 3 consecutive corrupt words → `err` high 3 cycles, `err_count`+3, `locked` falls after the 3rd, `index`=0. A clean restart relocks after 5 words.
- **Stall and wrap.** Drop `in_valid` for 10 cycles mid-lock, then resume with the correct next word → no error, outputs frozen during the gap. Stream through 100000 then 000001 → `index` goes 63→1, no error.
- **Zero word and clear.**
  - Feed 000000 in HUNT → ignored, stays unlocked.
  - Raise `err_clr` in the same cycle as a mismatch while locked → `err_count`=0 and `err` still pulses.
  - Hold `err_count` at saturation with ERR_W=2 → stays 3.
- **Asynchronous reset mid-lock.** Assert `rst_n`=0 between edges while locked with `err_count`=5 → all outputs 0 immediately, no clock edge needed.

Source files
------------

// File: rtl/lfsr6_checker.sv
// lfsr6_checker: receive-side checker for the 6-bit LFSR stream
// next(q) = {q[4:0], q[5]^q[4]}, period 63, all-zero word illegal.
// Hunts for a seed, verifies LOCK_CNT predicted words, then tracks the
// stream in LOCKED, flywheeling over corrupt words until UNLOCK_CNT
// consecutive misses drop lock.
// Optional feature: define LFSR6_CHK_INDEX_EN to build the sequence
// position lookup that drives `index`; otherwise `index` is tied to 0.
module lfsr6_checker #(
   parameter int unsigned LOCK_CNT   = 4,
   parameter int unsigned UNLOCK_CNT = 3,
   parameter int unsigned ERR_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [5:0]       in_data,
   input  logic             err_clr,
   output logic             locked,
   output logic             err,
   output logic [ERR_W-1:0] err_count,
   output logic [5:0]       index
);

   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

   state_t           st, st_next;
   logic [5:0]       pred, pred_next;
   logic [3:0]       match_cnt, match_next;
   logic [3:0]       miss_cnt, miss_next;
   logic             err_next;
   logic [ERR_W-1:0] cnt_next;
   logic             hit;

   function automatic logic [5:0] nxt(input logic [5:0] q);
      return {q[4:0], q[5] ^ q[4]};
   endfunction

   assign hit = (in_data == pred);

   // Next-state, prediction, counters and error pulse
   always_comb begin
      st_next    = st;
      pred_next  = pred;
      match_next = match_cnt;
      miss_next  = miss_cnt;
      err_next   = 1'b0;
      if (in_valid) begin
         case (st)
            HUNT: begin
               if (in_data != '0) begin
                  pred_next  = nxt(in_data);
                  match_next = '0;
                  st_next    = VERIFY;
               end
            end
            VERIFY: begin
               if (hit) begin
                  match_next = match_cnt + 4'd1;
                  pred_next  = nxt(in_data);
                  if (match_next == 4'(LOCK_CNT)) begin
                     st_next   = LOCKED;
                     miss_next = '0;
                  end
               end else if (in_data != '0) begin
                  pred_next  = nxt(in_data);
                  match_next = '0;
               end else begin
                  match_next = '0;
                  st_next    = HUNT;
               end
            end
            LOCKED: begin
               if (hit) begin
                  pred_next = nxt(in_data);
                  miss_next = '0;
               end else begin
                  // Flywheel on our own prediction; bad data never reseeds
                  err_next  = 1'b1;
                  pred_next = nxt(pred);
                  miss_next = miss_cnt + 4'd1;
                  if (miss_next == 4'(UNLOCK_CNT)) begin
                     st_next    = HUNT;
                     miss_next  = '0;
                     match_next = '0;
                  end
               end
            end
            default: st_next = HUNT;
         endcase
      end
   end

   // Saturating error counter; clear takes priority over a coincident error
   always_comb begin
      cnt_next = err_count;
      if (err_clr)
         cnt_next = '0;
      else if (err_next && (err_count != '1))
         cnt_next = err_count + 1'b1;
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= HUNT;
         pred      <= '0;
         match_cnt <= '0;
         miss_cnt  <= '0;
         locked    <= 1'b0;
         err       <= 1'b0;
         err_count <= '0;
      end else begin
         st        <= st_next;
         pred      <= pred_next;
         match_cnt <= match_next;
         miss_cnt  <= miss_next;
         locked    <= (st_next == LOCKED);
         err       <= err_next;
         err_count <= cnt_next;
      end
   end

`ifdef LFSR6_CHK_INDEX_EN
   logic [5:0] index_q, index_next;

   // Walks the sequence from 000001; each step is a constant compare
   function automatic logic [5:0] pos_of(input logic [5:0] w);
      logic [5:0] s;
      logic [5:0] p;
      s = 6'd1;
      p = '0;
      for (int unsigned k = 1; k <= 63; k++) begin
         if (s == w) p = 6'(k);
         s = nxt(s);
      end
      return p;
   endfunction

   // Position of the accepted word, or of the prediction while flywheeling
   always_comb begin
      index_next = index_q;
      if (in_valid) begin
         if (st_next != LOCKED)
            index_next = '0;
         else if ((st == LOCKED) && !hit)
            index_next = pos_of(pred);
         else
            index_next = pos_of(in_data);
      end
   end

   // Position register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) index_q <= '0;
      else        index_q <= index_next;
   end

   assign index = index_q;
`else
   assign index = '0;
`endif

endmodule

// File: tb/tb_lfsr6_checker.sv
// Self-checking bench for lfsr6_checker: table of hand-derived vectors,
// then hand-written wrap and asynchronous reset sequences. A second
// instance with ERR_W=2 shares the stimulus to observe saturation.
module tb_lfsr6_checker;

`ifdef LFSR6_CHK_INDEX_EN
   localparam bit IDX_EN = 1'b1;
`else
   localparam bit IDX_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [5:0]  in_data;
   logic        err_clr;
   logic        locked, err;
   logic [15:0] err_count;
   logic [5:0]  index;
   logic        s_locked, s_err;
   logic [1:0]  s_count;
   logic [5:0]  s_index;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        v;
      logic [5:0]  d;
      logic        c;
      logic        l;
      logic        e;
      logic [15:0] n;
      logic [1:0]  s;
      logic [5:0]  i;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];

   lfsr6_checker u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .err_clr(err_clr), .locked(locked), .err(err),
      .err_count(err_count), .index(index)
   );

   lfsr6_checker #(.ERR_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .err_clr(err_clr), .locked(s_locked), .err(s_err),
      .err_count(s_count), .index(s_index)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   function automatic logic [5:0] ei(input int p);
      return IDX_EN ? 6'(p) : 6'd0;
   endfunction

   function automatic logic [5:0] nx(input logic [5:0] q);
      return {q[4:0], q[5] ^ q[4]};
   endfunction

   function automatic void add(input logic v, input logic [5:0] d, input logic c,
                               input logic l, input logic e, input int n,
                               input int s, input logic [5:0] i);
      vec_t t;
      t.v = v; t.d = d; t.c = c; t.l = l; t.e = e;
      t.n = 16'(n); t.s = 2'(s); t.i = i;
      tbl.push_back(t);
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got=%0h want=%0h", nm, act, want);
      end
   endtask

   task automatic step(input string tag, input vec_t t);
      vec_t e;
      @(negedge clk);
      in_valid = t.v;
      in_data  = t.d;
      err_clr  = t.c;
      exp_q.push_back(t);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk({tag, ".locked"}, 16'(locked), 16'(e.l));
      chk({tag, ".err"}, 16'(err), 16'(e.e));
      chk({tag, ".err_count"}, err_count, e.n);
      chk({tag, ".sat_count"}, 16'(s_count), 16'(e.s));
      chk({tag, ".index"}, 16'(index), 16'(e.i));
   endtask

   initial begin
      vec_t       t;
      logic [5:0] w;
      int         p;

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; err_clr = 1'b0;

      // valid, data, clr, locked, err, count, sat count, index
      add(1, 6'h00, 0, 0, 0, 0, 0, 0);          // zero word ignored in HUNT
      add(1, 6'h01, 0, 0, 0, 0, 0, 0);          // seed
      add(1, 6'h02, 0, 0, 0, 0, 0, 0);
      add(1, 6'h04, 0, 0, 0, 0, 0, 0);
      add(1, 6'h08, 0, 0, 0, 0, 0, 0);
      add(1, 6'h10, 0, 1, 0, 0, 0, ei(5));      // 5th word locks
      add(1, 6'h21, 0, 1, 0, 0, 0, ei(6));
      add(1, 6'h3F, 0, 1, 1, 1, 1, ei(7));      // corrupt for 000011
      add(1, 6'h06, 0, 1, 0, 1, 1, ei(8));
      for (int k = 0; k < 10; k++)
         add(0, 6'h2A, 0, 1, 0, 1, 1, ei(8));   // stall: outputs frozen
      add(1, 6'h0C, 0, 1, 0, 1, 1, ei(9));
      add(1, 6'h00, 1, 1, 1, 0, 0, ei(10));     // zero mismatch + clear
      add(1, 6'h31, 0, 1, 0, 0, 0, ei(11));
      add(1, 6'h3F, 0, 1, 1, 1, 1, ei(12));     // loss of lock
      add(1, 6'h3F, 0, 1, 1, 2, 2, ei(13));
      add(1, 6'h3F, 0, 0, 1, 3, 3, 0);
      add(1, 6'h01, 0, 0, 0, 3, 3, 0);          // clean restart
      add(1, 6'h02, 0, 0, 0, 3, 3, 0);
      add(1, 6'h04, 0, 0, 0, 3, 3, 0);
      add(1, 6'h08, 0, 0, 0, 3, 3, 0);
      add(1, 6'h10, 0, 1, 0, 3, 3, ei(5));
      add(1, 6'h3F, 0, 1, 1, 4, 3, ei(6));      // narrow counter saturated
      add(1, 6'h03, 0, 1, 0, 4, 3, ei(7));

      #12;
      chk("reset.locked", 16'(locked), 16'd0);
      chk("reset.err", 16'(err), 16'd0);
      chk("reset.err_count", err_count, 16'd0);
      chk("reset.index", 16'(index), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < tbl.size(); k++)
         step($sformatf("vec%0d", k), tbl[k]);

      // Stream positions 8..63 then wrap to 1, 2
      w = 6'h06;
      p = 8;
      for (int k = 0; k < 58; k++) begin
         t.v = 1'b1; t.d = w; t.c = 1'b0; t.l = 1'b1; t.e = 1'b0;
         t.n = 16'd4; t.s = 2'd3; t.i = ei(p);
         step($sformatf("wrap_p%0d", p), t);
         w = nx(w);
         p = (p == 63) ? 1 : p + 1;
      end
      if (w != 6'h04) begin
         failures++;
         $display("FAIL wrap_word: got=%0h want=4", w);
      end

      // One more corrupt word so err_count reads 5 before reset
      t.v = 1'b1; t.d = 6'h3F; t.c = 1'b0; t.l = 1'b1; t.e = 1'b1;
      t.n = 16'd5; t.s = 2'd3; t.i = ei(3);
      step("pre_reset", t);

      // Asynchronous reset between edges
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("areset.locked", 16'(locked), 16'd0);
      chk("areset.err", 16'(err), 16'd0);
      chk("areset.err_count", err_count, 16'd0);
      chk("areset.index", 16'(index), 16'd0);
      chk("areset.sat_count", 16'(s_count), 16'd0);
      chk("areset.sat_locked", 16'(s_locked), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
